ps2_scan_capture: RTL

//  Receives PS/2 keyboard frames (device-clocked, 11-bit) and packs the result

---
 rtl/ps2_scan_capture.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_capture.sv
// PS/2 keyboard receiver: synchronises the device-clocked 11-bit frames, decodes
// F0/E0 prefixes and publishes a packed 32-bit status word for the memory map.
module ps2_scan_capture #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        err_clr,
  output logic [31:0] dataForPS2,
  output logic        code_strobe
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;

  state_t         state, state_n;
  logic [7:0]     shreg, shreg_n;
  logic [2:0]     bitcnt, bitcnt_n;
  logic           par_bit, par_n;
  logic [TW-1:0]  tcnt;
  logic           timeout;
  logic           accept, perr_set, ferr_set;

  logic           acc_valid;
  logic [7:0]     acc_byte;

  logic [7:0]     last_code, prev_code, evt_cnt;
  logic           flag_brk, flag_ext, pend_brk, pend_ext, perr, ferr;

  // NOTE: every clocked process uses non-blocking (<=) so all flops update
  // from the same pre-edge values; blocking here would reorder the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in  = data_sync[SYNC_STAGES-1];
  assign timeout = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      par_bit <= par_n;
      tcnt    <= (state == S_IDLE || fall) ? '0 : tcnt + TW'(1);
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    par_n    = par_bit;
    accept   = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (timeout) begin
      state_n  = S_IDLE;
      ferr_set = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_n  = S_DATA;
            bitcnt_n = '0;
          end
        end
        S_DATA: begin
          shreg_n  = {bit_in, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_n   = bit_in;
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n  = S_IDLE;
          ferr_set = !bit_in;
          perr_set = !(^{shreg, par_bit});
          accept   = bit_in && (^{shreg, par_bit});
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_valid <= 1'b0;
      acc_byte  <= '0;
    end else begin
      acc_valid <= accept;
      if (accept) acc_byte <= shreg;
    end
  end

  // Prefix bytes only arm flags; a non-prefix byte publishes and consumes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_code   <= '0;
      prev_code   <= '0;
      evt_cnt     <= '0;
      flag_brk    <= 1'b0;
      flag_ext    <= 1'b0;
      pend_brk    <= 1'b0;
      pend_ext    <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      code_strobe <= 1'b0;
    end else begin
      code_strobe <= 1'b0;
      perr        <= perr_set | (perr & ~err_clr);
      ferr        <= ferr_set | (ferr & ~err_clr);
      if (acc_valid) begin
        if (acc_byte == 8'hF0) begin
          pend_brk <= 1'b1;
        end else if (acc_byte == 8'hE0) begin
          pend_ext <= 1'b1;
        end else begin
          prev_code   <= last_code;
          last_code   <= acc_byte;
          evt_cnt     <= evt_cnt + 8'd1;
          flag_brk    <= pend_brk;
          flag_ext    <= pend_ext;
          pend_brk    <= 1'b0;
          pend_ext    <= 1'b0;
          code_strobe <= 1'b1;
        end
      end
    end
  end

  assign dataForPS2 = {4'b0000, ferr, perr, flag_ext, flag_brk, evt_cnt, prev_code, last_code};

endmodule
